score_overlay: RTL and testbench

Parametrised score-keeping and score-rendering stage for the Tetris VGA pipeline. Accepts line-clear events, accumulates a saturating multi-digit BCD score with a digit-serial adder, and overlays the score as seven-segment glyphs onto the incoming pixel colour. It sits between the playfield colour compositor and the VGA driver and adds one cycle of pixel latency.

---
 rtl/score_overlay.sv | 187 ++++++++++++++++++
 tb/tb_score_overlay.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_overlay.sv
// Score keeper and 7-segment overlay; optional leading-zero blanking via SCORE_LZB_EN.
// Pixel path: 1 cycle. Add: n+1 cycles (n = digits touched); score_bcd only updates after the full carry.
// Backpressure: add_ready low while an add is in flight or score_clear is high; held requests stall.
module score_overlay #(
  parameter int DIGITS = 4,
  parameter int X0     = 50,
  parameter int Y0     = 139,
  parameter int PITCH  = 25,
  parameter int SEG_W  = 20,
  parameter int SEG_T  = 5,
  parameter int ROW_H  = 7,
  parameter logic [11:0] FG = 12'hFFF,
  parameter logic [11:0] BG = 12'h000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  add_valid,
  output logic                  add_ready,
  input  logic [2:0]            lines,
  input  logic                  score_clear,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic [11:0]           pix_in,
  output logic [11:0]           pix_out,
  output logic                  in_score,
  output logic [4*DIGITS-1:0]   score_bcd
);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  localparam logic [3:0] LAST = 4'(DIGITS - 1);

  state_t              state;
  logic [4*DIGITS-1:0] work;
  logic [3:0]          addend;
  logic [3:0]          idx;
  logic [3:0]          points;
  logic [3:0]          cur;
  logic [4:0]          sum;
  logic [4:0]          sum_m10;
  logic                carry;

  always_comb begin
    case (lines)
      3'd1:    points = 4'd1;
      3'd2:    points = 4'd3;
      3'd3:    points = 4'd5;
      3'd4:    points = 4'd8;
      default: points = 4'd0;
    endcase
  end

  assign add_ready = (state == IDLE) && !score_clear;

  always_comb begin
    cur = 4'd0;
    for (int i = 0; i < DIGITS; i++)
      if (idx == 4'(i)) cur = work[4*i +: 4];
  end

  assign sum     = {1'b0, cur} + {1'b0, addend};
  assign sum_m10 = sum - 5'd10;
  assign carry   = sum >= 5'd10;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      work      <= '0;
      score_bcd <= '0;
      addend    <= 4'd0;
      idx       <= 4'd0;
    end else if (score_clear) begin
      state     <= IDLE;
      work      <= '0;
      score_bcd <= '0;
      addend    <= 4'd0;
      idx       <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (add_valid && points != 4'd0) begin
            addend <= points;
            idx    <= 4'd0;
            state  <= ADD;
          end
        end
        ADD: begin
          if (carry && idx == LAST) begin
            // carry out of the top digit: saturate at all nines
            work  <= {DIGITS{4'h9}};
            state <= DONE;
          end else begin
            for (int i = 0; i < DIGITS; i++)
              if (idx == 4'(i)) work[4*i +: 4] <= carry ? sum_m10[3:0] : sum[3:0];
            if (carry) begin
              addend <= 4'd1;
              idx    <= idx + 4'd1;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          score_bcd <= work;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // segment bits ordered {a,b,c,d,e,f,g}
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  logic [10:0] x11, y11;
  logic        row_a, row_b, row_g, row_c, row_d, in_rows;
  logic        hit_box, hit_seg;

  assign x11     = {1'b0, x};
  assign y11     = {1'b0, y};
  assign in_rows = y11 >= 11'(Y0) && y11 < 11'(Y0 + 5*ROW_H);
  assign row_a   = y11 >= 11'(Y0)           && y11 < 11'(Y0 + ROW_H);
  assign row_b   = y11 >= 11'(Y0 + ROW_H)   && y11 < 11'(Y0 + 2*ROW_H);
  assign row_g   = y11 >= 11'(Y0 + 2*ROW_H) && y11 < 11'(Y0 + 3*ROW_H);
  assign row_c   = y11 >= 11'(Y0 + 3*ROW_H) && y11 < 11'(Y0 + 4*ROW_H);
  assign row_d   = y11 >= 11'(Y0 + 4*ROW_H) && y11 < 11'(Y0 + 5*ROW_H);

  always_comb begin : render
    logic [3:0]  dv;
    logic [6:0]  sg;
    logic [10:0] xl;
    logic        lf, rt;
`ifdef SCORE_LZB_EN
    logic        nz;
    nz = 1'b0;
`endif
    hit_box = 1'b0;
    hit_seg = 1'b0;
    dv = 4'd0;
    sg = 7'd0;
    xl = 11'd0;
    lf = 1'b0;
    rt = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      dv = score_bcd[4*k +: 4];
      sg = seg7(dv);
`ifdef SCORE_LZB_EN
      nz = nz | (dv != 4'd0);
      if (!nz && k != 0) sg = 7'd0;
`endif
      xl = 11'(X0 + PITCH*(DIGITS - 1 - k));
      lf = x11 < xl + 11'(SEG_T);
      rt = x11 >= xl + 11'(SEG_W - SEG_T);
      if (in_rows && x11 >= xl && x11 <= xl + 11'(SEG_W - 1)) begin
        hit_box = 1'b1;
        hit_seg = (row_a & sg[6]) | (row_g & sg[0]) | (row_d & sg[3]) |
                  (row_b & ((lf & sg[1]) | (rt & sg[5]))) |
                  (row_c & ((lf & sg[2]) | (rt & sg[4])));
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_out  <= 12'h000;
      in_score <= 1'b0;
    end else begin
      pix_out  <= hit_box ? (hit_seg ? FG : BG) : pix_in;
      in_score <= hit_box;
    end
  end

endmodule

// File: tb/tb_score_overlay.sv
// Bench for score_overlay: pixel vector table plus scoreboarded add sequences.
module tb_score_overlay;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        add_valid = 1'b0;
  logic        add_ready;
  logic [2:0]  lines = 3'd0;
  logic        score_clear = 1'b0;
  logic [9:0]  x = 10'd0;
  logic [9:0]  y = 10'd0;
  logic [11:0] pix_in = 12'h000;
  logic [11:0] pix_out;
  logic        in_score;
  logic [15:0] score_bcd;

  score_overlay dut (
    .clk(clk), .resetn(resetn), .add_valid(add_valid), .add_ready(add_ready),
    .lines(lines), .score_clear(score_clear), .x(x), .y(y), .pix_in(pix_in),
    .pix_out(pix_out), .in_score(in_score), .score_bcd(score_bcd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int model = 0;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] pin;
    logic [11:0] epix;
    logic        ein;
    logic        blk;
  } pvec_t;

  typedef struct {
    logic [11:0] epix;
    logic        ein;
  } pexp_t;

  pvec_t       pv[20];
  pexp_t       pix_q[$];
  logic [15:0] score_q[$];
  int          low_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int pts_of(input logic [2:0] l);
    case (l)
      3'd1: return 1;
      3'd2: return 3;
      3'd3: return 5;
      3'd4: return 8;
      default: return 0;
    endcase
  endfunction

  task automatic pix_drive(input logic [9:0] px, input logic [9:0] py, input logic [11:0] pin,
                           input logic [11:0] epix, input logic ein, input logic blk);
    pexp_t e;
    x = px;
    y = py;
    pix_in = pin;
    e.epix = epix;
    e.ein = ein;
`ifdef SCORE_LZB_EN
    if (blk && ein) e.epix = 12'h000;
`endif
    pix_q.push_back(e);
  endtask

  task automatic pix_pop();
    pexp_t e;
    if (pix_q.size() == 0) begin
      check("pix_queue_empty", 32'd0, 32'd1);
    end else begin
      e = pix_q.pop_front();
      check("pix_out", 32'(pix_out), 32'(e.epix));
      check("in_score", 32'(in_score), 32'(e.ein));
    end
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      if (pix_q.size() > 0) pix_pop();
      pix_drive(pv[i].x, pv[i].y, pv[i].pin, pv[i].epix, pv[i].ein, pv[i].blk);
    end
    @(negedge clk);
    pix_pop();
  endtask

  task automatic wait_idle(input logic [15:0] old_bcd, output int cnt);
    cnt = 0;
    while (add_ready == 1'b0 && cnt < 40) begin
      check("no_tear", 32'(score_bcd), 32'(old_bcd));
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic add_event(input logic [2:0] l);
    int pts, n, t, cnt;
    int d[4];
    logic c;
    logic [15:0] old_bcd;
    pts = pts_of(l);
    old_bcd = to_bcd(model);
    n = 0;
    if (pts != 0) begin
      t = model;
      for (int i = 0; i < 4; i++) begin
        d[i] = t % 10;
        t = t / 10;
      end
      n = 1;
      c = (d[0] + pts >= 10);
      for (int i = 1; i < 4 && c; i++) begin
        n++;
        c = (d[i] == 9);
      end
      model = (model + pts > 9999) ? 9999 : model + pts;
    end
    score_q.push_back(to_bcd(model));
    low_q.push_back(pts == 0 ? 0 : n + 1);
    @(negedge clk);
    add_valid = 1'b1;
    lines = l;
    #1 check("ready_at_req", 32'(add_ready), 32'd1);
    @(negedge clk);
    add_valid = 1'b0;
    wait_idle(old_bcd, cnt);
    check("ready_low_cycles", 32'(cnt), 32'(low_q.pop_front()));
    check("score", 32'(score_bcd), 32'(score_q.pop_front()));
  endtask

  initial begin
    int cnt;
    // x, y, pin, expected pix, expected in_score, digit is a leading zero at this score
    pv[0]  = '{10'd52,   10'd142,  12'h0F0, 12'hFFF, 1'b1, 1'b1};
    pv[1]  = '{10'd300,  10'd300,  12'h0F0, 12'h0F0, 1'b0, 1'b0};
    pv[2]  = '{10'd60,   10'd156,  12'hABC, 12'h000, 1'b1, 1'b1};
    pv[3]  = '{10'd52,   10'd149,  12'h123, 12'hFFF, 1'b1, 1'b1};
    pv[4]  = '{10'd60,   10'd149,  12'h123, 12'h000, 1'b1, 1'b1};
    pv[5]  = '{10'd144,  10'd170,  12'h456, 12'hFFF, 1'b1, 1'b0};
    pv[6]  = '{10'd145,  10'd170,  12'h456, 12'h456, 1'b0, 1'b0};
    pv[7]  = '{10'd130,  10'd174,  12'h789, 12'h789, 1'b0, 1'b0};
    pv[8]  = '{10'd125,  10'd138,  12'h321, 12'h321, 1'b0, 1'b0};
    pv[9]  = '{10'd70,   10'd150,  12'h654, 12'h654, 1'b0, 1'b0};
    pv[10] = '{10'd120,  10'd163,  12'h987, 12'h987, 1'b0, 1'b0};
    pv[11] = '{10'd140,  10'd163,  12'h111, 12'hFFF, 1'b1, 1'b0};
    pv[12] = '{10'd126,  10'd163,  12'h222, 12'hFFF, 1'b1, 1'b0};
    pv[13] = '{10'd1023, 10'd1023, 12'hF0F, 12'hF0F, 1'b0, 1'b0};
    // score 0016
    pv[14] = '{10'd142,  10'd149,  12'h333, 12'h000, 1'b1, 1'b0};
    pv[15] = '{10'd127,  10'd149,  12'h333, 12'hFFF, 1'b1, 1'b0};
    pv[16] = '{10'd102,  10'd142,  12'h444, 12'h000, 1'b1, 1'b0};
    pv[17] = '{10'd117,  10'd149,  12'h444, 12'hFFF, 1'b1, 1'b0};
    pv[18] = '{10'd110,  10'd156,  12'h555, 12'h000, 1'b1, 1'b0};
    pv[19] = '{10'd85,   10'd170,  12'h555, 12'hFFF, 1'b1, 1'b1};

    #12;
    check("rst_pix_out", 32'(pix_out), 32'h0);
    check("rst_in_score", 32'(in_score), 32'h0);
    check("rst_score", 32'(score_bcd), 32'h0);
    check("rst_ready", 32'(add_ready), 32'h1);
    @(negedge clk);
    resetn = 1'b1;

    run_table(0, 13);

    add_event(3'd4);
    add_event(3'd4);
    add_event(3'd0);
    add_event(3'd6);

    run_table(14, 19);

    // clear arrives while an add is in flight, requester keeps add_valid high
    @(negedge clk);
    add_valid = 1'b1;
    lines = 3'd4;
    @(negedge clk);
    check("busy_in_add", 32'(add_ready), 32'd0);
    score_clear = 1'b1;
    #1 check("ready_during_clear", 32'(add_ready), 32'd0);
    @(negedge clk);
    score_clear = 1'b0;
    model = 0;
    check("clear_score", 32'(score_bcd), 32'h0);
    #1 check("ready_after_clear", 32'(add_ready), 32'd1);
    @(negedge clk);
    add_valid = 1'b0;
    model = 8;
    wait_idle(16'h0000, cnt);
    check("stalled_req_low", 32'(cnt), 32'd2);
    check("stalled_req_score", 32'(score_bcd), 32'h0008);

    // clear in idle blocks a simultaneous request
    @(negedge clk);
    add_valid = 1'b1;
    lines = 3'd4;
    score_clear = 1'b1;
    #1 check("ready_clear_idle", 32'(add_ready), 32'd0);
    @(negedge clk);
    add_valid = 1'b0;
    score_clear = 1'b0;
    model = 0;
    check("clear_idle_score", 32'(score_bcd), 32'h0);
    repeat (4) @(negedge clk);
    check("clear_blocks_accept", 32'(score_bcd), 32'h0);
    check("clear_idle_ready", 32'(add_ready), 32'd1);

    // asynchronous reset in the middle of an add
    add_event(3'd2);
    @(negedge clk);
    x = 10'd300;
    y = 10'd300;
    pix_in = 12'h0F0;
    add_valid = 1'b1;
    lines = 3'd1;
    @(negedge clk);
    add_valid = 1'b0;
    check("pre_reset_pix", 32'(pix_out), 32'h0F0);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_ready", 32'(add_ready), 32'd1);
    check("async_rst_score", 32'(score_bcd), 32'h0);
    check("async_rst_pix", 32'(pix_out), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    model = 0;

    // score 0007: thousands digit is a leading zero
    add_event(3'd3);
    add_event(3'd1);
    add_event(3'd1);
    @(negedge clk);
    pix_drive(10'd55, 10'd140, 12'h0F0, 12'hFFF, 1'b1, 1'b1);
    @(negedge clk);
    pix_pop();

    // climb from 7 to 9999 in steps of 8, then saturate
    repeat (1249) add_event(3'd4);
    add_event(3'd1);
    add_event(3'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
